branch_resolve_ctrl: RTL and testbench
======================================

# branch_resolve_ctrl

Sequences branch resolution around the 2-bit branch predictor. It records each prediction issued in ID in a small in-flight queue and compares the oldest entry with the EX-stage outcome. It drives the predictor's update strobe and, on a misprediction, runs a redirect/flush sequence that steers the PC and squashes wrong-path instructions. It sits between the predictor, the hazard/flush logic and the PC mux.

## Interface
- `DEPTH`, 4: in-flight prediction queue entries (power of 2, ≥2).
- `PC_W`, 32: PC width.
- `FLUSH_CYC`, 2: cycles `flush_o` stays high after a redirect (≥1).

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `id_branch_i`  in  1  ID holds a branch this cycle.
- `id_predict_i`  in  1  predictor output for that branch (1 = taken).
- `id_target_i`  in  PC_W  branch target address.
- `id_fallthru_i`  in  PC_W  PC+4 of the branch.
- `stall_i`  in  1  pipeline stall; blocks push.
- `ex_branch_i`  in  1  EX resolves a branch this cycle.
- `ex_taken_i`  in  1  actual outcome; valid with `ex_branch_i`.
- `pred_upd_o`  out  1  predictor update strobe; one pulse per resolved branch.
- `pred_taken_o`  out  1  outcome passed to the predictor; valid with `pred_upd_o`.
- `redirect_o`  out  1  one-cycle PC override.
- `redirect_pc_o`  out  PC_W  corrected PC; valid with `redirect_o`.
- `flush_o`  out  1  squash IF/ID.
- `busy_o`  out  1  FSM is not IDLE.
- `ovf_o`  out  1  sticky: a push was attempted while the queue was full.
- `err_o`  out  1  sticky: a resolution arrived while the queue was empty.

## Operation
- Queue entry is {pred, target, fallthru}. Circular buffer with log2(DEPTH)+1-bit read/write pointers.
  - Full when the MSBs differ and the rest are equal.
  - Empty when the pointers are equal.
  - Pointers wrap naturally.
- Push condition: `id_branch_i & ~stall_i & state==IDLE & ~full`.
  - Push while full: the entry is dropped and `ovf_o` is set.
- Pop condition: `ex_branch_i & ~empty`, in any state.
  - Resolution while empty: no pop, no update, and `err_o` is set.
- Push and pop in the same cycle are both performed; occupancy is unchanged, including when full.
- Mispredict: head.pred != `ex_taken_i` on a pop.
- FSM:
  - IDLE: on a pop, register `pred_upd_o`=1 and `pred_taken_o`=`ex_taken_i`.
  - IDLE, on a mispredict in addition:
    - register `redirect_o`=1.
    - register `redirect_pc_o` = `ex_taken_i` ? head.target : head.fallthru.
    - clear the whole queue (read pointer ← write pointer after the pop); all remaining entries are wrong-path.
    - go to FLUSH.
  - FLUSH: `flush_o`=1 and pushes are blocked. A down-counter loaded with FLUSH_CYC−1 returns the FSM to IDLE at 0. Any `ex_branch_i` in FLUSH belongs to the wrong path: no update, no `err_o`.
- Sticky flags clear only on reset.

## Timing
- All outputs are registered.
- A resolution in cycle N produces `pred_upd_o`, `pred_taken_o` and `redirect_o` in cycle N+1.
- `flush_o` is high in cycles N+1 through N+FLUSH_CYC.
- `busy_o` is high for the same window as `flush_o`.
- `pred_upd_o` and `redirect_o` are single-cycle pulses; back-to-back correct resolutions give back-to-back update pulses.
- Push in cycle N: the entry is visible at the head for a resolution from cycle N+1.
- Reset values:
  - outputs: all 0, and `redirect_pc_o`=0.
  - pointers: 0.
  - FSM: IDLE.
  - counter: 0.
  - Reset asserted mid-flush aborts immediately; after release the block is empty and in IDLE.

## Structure
- Shared package (branch_pkg):
  - FSM state enum {IDLE, FLUSH}.
  - predictor state constants (STRONGLY_NON_TAKEN=2'b00 … STRONGLY_TAKEN=2'b11), so the predictor and its controller agree.
  - queue entry struct.
- One sub-module: `branch_pred_fifo`, a parameterised queue with push, pop, clear, full, empty and head outputs.
- The FSM, counter and compare logic live in the top module.

## Test plan
- Reset, then push a single entry (pred=1, target=0x100, fallthru=0x44); resolve with taken=1 two cycles later → `pred_upd_o`=1 and `pred_taken_o`=1 for one cycle; `redirect_o`=0; `flush_o`=0.
- Push pred=1 (target 0x200, fallthru 0x84) followed by 2 more entries; resolve the first with taken=0 → next cycle: `redirect_o`=1, `redirect_pc_o`=0x84, `flush_o` high for exactly 2 cycles, queue empty; an `ex_branch_i` during flush causes no update.
- Fill with DEPTH pushes, push once more → `ovf_o`=1 and occupancy stays 4; then a simultaneous push and pop in one cycle → occupancy stays 4 and the head advances in order.
- `ex_branch_i` with the queue empty after reset → `err_o`=1, no `pred_upd_o`; `err_o` stays set until `rst_i`.
- Push with `stall_i`=1 → no entry is queued; run 10 push/pop pairs to wrap the pointers → FIFO order preserved.
- Assert `rst_i` in the first FLUSH cycle → all outputs go to 0 asynchronously; after release `busy_o`=0 and the queue is empty.

Source files
------------

// File: rtl/branch_pkg.sv
// ----------------------------------------------------------------------------
// branch_pkg
// Shared types and constants for branch resolution. The predictor and its
// resolution controller both import this so they agree on counter encodings,
// the controller FSM states and the layout of an in-flight prediction record.
// ----------------------------------------------------------------------------
package branch_pkg;

    // Resolution controller FSM states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } br_state_t;

    // 2-bit saturating predictor counter encoding. MSB is the taken prediction.
    localparam logic [1:0] STRONGLY_NON_TAKEN = 2'b00;
    localparam logic [1:0] WEAKLY_NON_TAKEN   = 2'b01;
    localparam logic [1:0] WEAKLY_TAKEN       = 2'b10;
    localparam logic [1:0] STRONGLY_TAKEN     = 2'b11;

    // Default PC width of the in-flight record.
    localparam int BR_PC_W = 32;

    // One in-flight prediction: what ID guessed and both candidate PCs, so a
    // wrong guess can be corrected without recomputing either address.
    typedef struct packed {
        logic               pred;
        logic [BR_PC_W-1:0] target;
        logic [BR_PC_W-1:0] fallthru;
    } br_entry_t;

    // Next predictor counter value after an update with the real outcome.
    function automatic logic [1:0] pred_next(input logic [1:0] st, input logic taken);
        logic [1:0] nxt;
        nxt = st;
        if (taken) begin
            if (st != STRONGLY_TAKEN) nxt = st + 2'd1;
        end else begin
            if (st != STRONGLY_NON_TAKEN) nxt = st - 2'd1;
        end
        return nxt;
    endfunction

    // Taken prediction implied by a counter value.
    function automatic logic pred_is_taken(input logic [1:0] st);
        return (st == WEAKLY_TAKEN) || (st == STRONGLY_TAKEN);
    endfunction

endpackage

// File: rtl/branch_pred_fifo.sv
// ----------------------------------------------------------------------------
// branch_pred_fifo
// Circular queue of in-flight branch predictions, oldest entry at the head.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   i_push              write {i_pred, i_target, i_fallthru} at the tail
//   i_pop               retire the head entry
//   i_clear             discard everything (applied after this cycle's push)
//   o_full, o_empty     occupancy status
//   o_head_*            fields of the oldest entry (undefined when empty)
//
// The caller owns overflow/underflow policy: i_push is only raised when there
// is room (or the head retires in the same cycle) and i_pop only when
// not empty.
// ----------------------------------------------------------------------------
module branch_pred_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            i_push,
    input  logic            i_pred,
    input  logic [PC_W-1:0] i_target,
    input  logic [PC_W-1:0] i_fallthru,
    input  logic            i_pop,
    input  logic            i_clear,
    output logic            o_full,
    output logic            o_empty,
    output logic            o_head_pred,
    output logic [PC_W-1:0] o_head_target,
    output logic [PC_W-1:0] o_head_fallthru
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic [AW:0]     w_wr_next;
    logic [AW:0]     w_rd_next;

    logic            r_pred     [DEPTH];
    logic [PC_W-1:0] r_target   [DEPTH];
    logic [PC_W-1:0] r_fallthru [DEPTH];

    assign w_wr_next = r_wr_ptr + {{AW{1'b0}}, i_push};

    // A clear drops every entry, including one pushed in the same cycle: that
    // branch is younger than the mispredicted one and is on the wrong path.
    assign w_rd_next = i_clear ? w_wr_next
                               : (r_rd_ptr + {{AW{1'b0}}, i_pop});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
        end
    end

    // Storage needs no reset; entries are only read between push and pop.
    always_ff @(posedge clk_i) begin
        if (i_push) begin
            r_pred[r_wr_ptr[AW-1:0]]     <= i_pred;
            r_target[r_wr_ptr[AW-1:0]]   <= i_target;
            r_fallthru[r_wr_ptr[AW-1:0]] <= i_fallthru;
        end
    end

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign o_head_pred     = r_pred[r_rd_ptr[AW-1:0]];
    assign o_head_target   = r_target[r_rd_ptr[AW-1:0]];
    assign o_head_fallthru = r_fallthru[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ----------------------------------------------------------------------------
// branch_resolve_ctrl
// Tracks predictions issued in ID, checks the oldest one against the EX
// outcome, strobes the predictor update and, on a wrong guess, redirects the
// PC and squashes IF/ID for FLUSH_CYC cycles.
//
// Ports
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   id_branch_i / id_predict_i    branch in ID and its predicted direction
//   id_target_i / id_fallthru_i   taken and not-taken PCs of that branch
//   stall_i                       pipeline stall, blocks recording
//   ex_branch_i / ex_taken_i      branch resolving in EX and its outcome
//   pred_upd_o / pred_taken_o     predictor update strobe and outcome
//   redirect_o / redirect_pc_o    one-cycle PC override and corrected PC
//   flush_o                       squash IF/ID
//   busy_o                        controller not idle
//   ovf_o                         sticky: record dropped, queue was full
//   err_o                         sticky: resolution with nothing in flight
//
// state | meaning
// IDLE  | recording predictions and resolving them
// FLUSH | wrong path being squashed; recording and updates suppressed
// ----------------------------------------------------------------------------
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PC_W      = 32,
    parameter int FLUSH_CYC = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            id_branch_i,
    input  logic            id_predict_i,
    input  logic [PC_W-1:0] id_target_i,
    input  logic [PC_W-1:0] id_fallthru_i,
    input  logic            stall_i,
    input  logic            ex_branch_i,
    input  logic            ex_taken_i,
    output logic            pred_upd_o,
    output logic            pred_taken_o,
    output logic            redirect_o,
    output logic [PC_W-1:0] redirect_pc_o,
    output logic            flush_o,
    output logic            busy_o,
    output logic            ovf_o,
    output logic            err_o
);

    localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    br_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_pred_upd;
    logic            r_pred_taken;
    logic            r_redirect;
    logic [PC_W-1:0] r_redirect_pc;
    logic            r_flush;
    logic            r_busy;
    logic            r_ovf;
    logic            r_err;

    logic            w_idle;
    logic            w_full;
    logic            w_empty;
    logic            w_head_pred;
    logic [PC_W-1:0] w_head_target;
    logic [PC_W-1:0] w_head_fallthru;
    logic            w_push_req;
    logic            w_push;
    logic            w_pop;
    logic            w_mispredict;
    logic            w_ovf_set;
    logic            w_err_set;

    assign w_idle     = (r_state == IDLE);
    assign w_push_req = id_branch_i & ~stall_i & w_idle;
    assign w_pop      = ex_branch_i & ~w_empty;

    // When full, a push still fits if the head retires in the same cycle, so
    // occupancy stays at DEPTH instead of losing the new record.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & w_full & ~w_pop;

    // In FLUSH the queue has just been cleared, so any EX branch is wrong-path
    // and must not be reported as an underflow.
    assign w_err_set  = ex_branch_i & w_empty & w_idle;

    assign w_mispredict = w_pop & w_idle & (w_head_pred != ex_taken_i);

    branch_pred_fifo #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) u_fifo (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .i_push          (w_push),
        .i_pred          (id_predict_i),
        .i_target        (id_target_i),
        .i_fallthru      (id_fallthru_i),
        .i_pop           (w_pop),
        .i_clear         (w_mispredict),
        .o_full          (w_full),
        .o_empty         (w_empty),
        .o_head_pred     (w_head_pred),
        .o_head_target   (w_head_target),
        .o_head_fallthru (w_head_fallthru)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_pred_upd    <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_flush       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_pred_upd <= 1'b0;
            r_redirect <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_pred_upd   <= 1'b1;
                        r_pred_taken <= ex_taken_i;
                    end
                    if (w_mispredict) begin
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= ex_taken_i ? w_head_target : w_head_fallthru;
                        r_state       <= FLUSH;
                        r_cnt         <= CNT_W'(FLUSH_CYC - 1);
                        r_flush       <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_flush <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_flush <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_ovf_set) r_ovf <= 1'b1;
            if (w_err_set) r_err <= 1'b1;
        end
    end

    assign pred_upd_o    = r_pred_upd;
    assign pred_taken_o  = r_pred_taken;
    assign redirect_o    = r_redirect;
    assign redirect_pc_o = r_redirect_pc;
    assign flush_o       = r_flush;
    assign busy_o        = r_busy;
    assign ovf_o         = r_ovf;
    assign err_o         = r_err;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;

    localparam int DEPTH     = 4;
    localparam int PC_W      = 32;
    localparam int FLUSH_CYC = 2;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            id_branch_i = 1'b0;
    logic            id_predict_i = 1'b0;
    logic [PC_W-1:0] id_target_i = '0;
    logic [PC_W-1:0] id_fallthru_i = '0;
    logic            stall_i = 1'b0;
    logic            ex_branch_i = 1'b0;
    logic            ex_taken_i = 1'b0;
    logic            pred_upd_o;
    logic            pred_taken_o;
    logic            redirect_o;
    logic [PC_W-1:0] redirect_pc_o;
    logic            flush_o;
    logic            busy_o;
    logic            ovf_o;
    logic            err_o;

    always #5 clk_i = ~clk_i;

    branch_resolve_ctrl #(
        .DEPTH     (DEPTH),
        .PC_W      (PC_W),
        .FLUSH_CYC (FLUSH_CYC)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_branch_i   (id_branch_i),
        .id_predict_i  (id_predict_i),
        .id_target_i   (id_target_i),
        .id_fallthru_i (id_fallthru_i),
        .stall_i       (stall_i),
        .ex_branch_i   (ex_branch_i),
        .ex_taken_i    (ex_taken_i),
        .pred_upd_o    (pred_upd_o),
        .pred_taken_o  (pred_taken_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .flush_o       (flush_o),
        .busy_o        (busy_o),
        .ovf_o         (ovf_o),
        .err_o         (err_o)
    );

    typedef struct {
        logic            pred;
        logic [PC_W-1:0] tgt;
        logic [PC_W-1:0] ft;
    } ent_t;

    typedef struct {
        logic            upd;
        logic            taken;
        logic            redir;
        logic [PC_W-1:0] pc;
        logic            flush;
        logic            busy;
        logic            ovf;
        logic            err;
    } exp_t;

    int errors = 0;
    int checks = 0;

    // Reference model state
    ent_t            mq[$];
    exp_t            exq[$];
    int              m_flush_left = 0;
    logic            m_taken = 1'b0;
    logic [PC_W-1:0] m_pc = '0;
    logic            m_ovf = 1'b0;
    logic            m_err = 1'b0;

    task automatic check(input string tag, input logic [PC_W-1:0] obs, input logic [PC_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".upd"},   PC_W'(pred_upd_o),   '0);
        check({tag, ".taken"}, PC_W'(pred_taken_o), '0);
        check({tag, ".redir"}, PC_W'(redirect_o),   '0);
        check({tag, ".pc"},    redirect_pc_o,       '0);
        check({tag, ".flush"}, PC_W'(flush_o),      '0);
        check({tag, ".busy"},  PC_W'(busy_o),       '0);
        check({tag, ".ovf"},   PC_W'(ovf_o),        '0);
        check({tag, ".err"},   PC_W'(err_o),        '0);
    endtask

    // Drives one cycle of stimulus, predicts the registered outputs for the
    // next cycle into the scoreboard, then compares after the edge.
    task automatic step(input string tag,
                        input logic br, input logic pred,
                        input logic [PC_W-1:0] tgt, input logic [PC_W-1:0] ft,
                        input logic stall, input logic exb, input logic ext);
        ent_t h;
        ent_t n;
        exp_t e;
        logic idle, pop, full, push, mis;
        id_branch_i   = br;
        id_predict_i  = pred;
        id_target_i   = tgt;
        id_fallthru_i = ft;
        stall_i       = stall;
        ex_branch_i   = exb;
        ex_taken_i    = ext;

        idle = (m_flush_left == 0);
        pop  = exb && (mq.size() != 0);
        full = (mq.size() == DEPTH);
        push = br && !stall && idle && (!full || pop);
        if (br && !stall && idle && full && !pop) m_ovf = 1'b1;
        if (exb && (mq.size() == 0) && idle) m_err = 1'b1;
        mis   = 1'b0;
        e.upd = 1'b0;
        e.redir = 1'b0;
        if (pop) begin
            h = mq.pop_front();
            if (idle) begin
                e.upd   = 1'b1;
                m_taken = ext;
                if (h.pred != ext) begin
                    mis     = 1'b1;
                    e.redir = 1'b1;
                    m_pc    = ext ? h.tgt : h.ft;
                end
            end
        end
        if (push) begin
            n.pred = pred;
            n.tgt  = tgt;
            n.ft   = ft;
            mq.push_back(n);
        end
        if (mis) begin
            mq.delete();
            m_flush_left = FLUSH_CYC;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end
        e.taken = m_taken;
        e.pc    = m_pc;
        e.flush = (m_flush_left > 0);
        e.busy  = (m_flush_left > 0);
        e.ovf   = m_ovf;
        e.err   = m_err;
        exq.push_back(e);

        @(posedge clk_i);
        #1;
        e = exq.pop_front();
        check({tag, ".upd"},   PC_W'(pred_upd_o),   PC_W'(e.upd));
        check({tag, ".taken"}, PC_W'(pred_taken_o), PC_W'(e.taken));
        check({tag, ".redir"}, PC_W'(redirect_o),   PC_W'(e.redir));
        check({tag, ".pc"},    redirect_pc_o,       e.pc);
        check({tag, ".flush"}, PC_W'(flush_o),      PC_W'(e.flush));
        check({tag, ".busy"},  PC_W'(busy_o),       PC_W'(e.busy));
        check({tag, ".ovf"},   PC_W'(ovf_o),        PC_W'(e.ovf));
        check({tag, ".err"},   PC_W'(err_o),        PC_W'(e.err));
    endtask

    task automatic push(input string tag, input logic pred, input logic [PC_W-1:0] tgt,
                        input logic [PC_W-1:0] ft);
        step(tag, 1'b1, pred, tgt, ft, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resolve(input string tag, input logic ext);
        step(tag, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, ext);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset(input string tag);
        rst_i         = 1'b1;
        id_branch_i   = 1'b0;
        stall_i       = 1'b0;
        ex_branch_i   = 1'b0;
        #1;
        check_zero(tag);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        mq.delete();
        exq.delete();
        m_flush_left = 0;
        m_taken = 1'b0;
        m_pc    = '0;
        m_ovf   = 1'b0;
        m_err   = 1'b0;
    endtask

    initial begin
        // reset state
        apply_reset("rst0");
        idle("rst0_idle");

        // single correct resolution, two cycles after the push
        push("t1_push", 1'b1, 32'h100, 32'h44);
        idle("t1_gap");
        resolve("t1_res", 1'b1);
        idle("t1_after");

        // mispredict with two younger entries in flight
        push("t2_p0", 1'b1, 32'h200, 32'h84);
        push("t2_p1", 1'b0, 32'h300, 32'h88);
        push("t2_p2", 1'b1, 32'h400, 32'h8c);
        resolve("t2_mis", 1'b0);
        step("t2_flush_ex", 1'b1, 1'b1, 32'h500, 32'h90, 1'b0, 1'b1, 1'b1);
        idle("t2_idle0");
        idle("t2_idle1");
        resolve("t2_empty", 1'b0);
        apply_reset("rst1");

        // fill, overflow, full push+pop, then drain in order
        push("t3_p0", 1'b1, 32'h1000, 32'h1004);
        push("t3_p1", 1'b0, 32'h1100, 32'h1104);
        push("t3_p2", 1'b0, 32'h1200, 32'h1204);
        push("t3_p3", 1'b1, 32'h1300, 32'h1304);
        push("t3_ovf", 1'b1, 32'h1400, 32'h1404);
        step("t3_pushpop", 1'b1, 1'b0, 32'h1500, 32'h1504, 1'b0, 1'b1, 1'b1);
        resolve("t3_r1", 1'b0);
        resolve("t3_r2", 1'b0);
        resolve("t3_r3", 1'b1);
        resolve("t3_r4mis", 1'b1);
        idle("t3_fl0");
        idle("t3_fl1");
        resolve("t3_empty", 1'b1);
        apply_reset("rst2");

        // resolution with nothing in flight; error stays sticky
        resolve("t4_err", 1'b1);
        idle("t4_hold0");
        push("t4_push", 1'b0, 32'h2000, 32'h2004);
        resolve("t4_ok", 1'b0);
        idle("t4_hold1");
        apply_reset("rst3");

        // stalled push is not recorded
        step("t5_stall", 1'b1, 1'b1, 32'h3000, 32'h3004, 1'b1, 1'b0, 1'b0);
        push("t5_push", 1'b0, 32'h3100, 32'h3104);
        resolve("t5_res", 1'b0);

        // pointer wrap: overlapping push/pop pairs keep order
        push("t5_w0", 1'b1, 32'h4000, 32'h8000);
        for (int i = 1; i <= 10; i++) begin
            step($sformatf("t5_wrap%0d", i), 1'b1, ((i % 3) == 0),
                 32'h4000 + PC_W'(i * 16), 32'h8000 + PC_W'(i * 16),
                 1'b0, 1'b1, (((i - 1) % 3) == 0));
        end
        resolve("t5_wmis", 1'b1);
        idle("t5_wfl0");
        idle("t5_wfl1");

        // reset asserted in the first flush cycle
        push("t6_push", 1'b1, 32'h700, 32'h704);
        resolve("t6_mis", 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        check_zero("t6_async");
        apply_reset("rst4");
        idle("t6_after");
        resolve("t6_empty", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
